ks_adder: RTL and testbench
===========================

# ks_adder

Registered 16-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out. It serves as the Kogge-Stone entry in the parallel-prefix adder comparison set. Sum and carry are computed by a log2(WIDTH)-level radix-2 prefix tree and captured in an output register. The block sits as a pipelined arithmetic stage between registered operand sources and downstream logic.

## Interface
- WIDTH, 16, operand and sum width; must be a power of two ≥ 2; the prefix tree has log2(WIDTH) levels (4 at default).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in.
- Sum  output  WIDTH  registered (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  registered carry-out, bit WIDTH of A + B + Cin.

## Operation
- Pre-processing per bit i: g_i = A_i & B_i, p_i = A_i ^ B_i.
- Cin is folded in as a level-0 generate at position −1: G_{-1} = Cin, P_{-1} = 0. Equivalently, g_0' = g_0 | (p_0 & Cin).
- Prefix level k (k = 0..log2(WIDTH)−1), span d = 2^k.
  - For i ≥ d: G_i = G_i | (P_i & G_{i−d}), P_i = P_i & P_{i−d}.
  - For i < d: buffer pass-through.
  - Black cells compute both G and P. Gray cells (final span reaching bit 0/Cin) compute G only.
- Carries: c_0 = Cin, c_{i+1} = G_{i:0} including Cin.
- Sum_i = p_i ^ c_i. Cout = c_WIDTH.
- No overflow flag. Unsigned wrap-around is the only out-of-range behaviour.
- The result must equal the arithmetic sum bit-exactly for all 2^(2·WIDTH+1) input combinations.

## Timing
- Sum and Cout are registered on the rising edge of clk.
- Latency: 1 cycle from operands to outputs (2 cycles with the Configuration feature enabled). Throughput: one addition per cycle.
- There is no handshake and no valid signal. Every clock edge captures the current inputs.
- Inputs may change at any time; they must be stable for setup/hold around the rising edge.
- Reset values: Sum = 0, Cout = 0, and any internal pipeline registers = 0.
  - Reset asserts immediately, independent of clk.
  - Release is synchronous in effect: the first capture happens on the first rising edge with rst_n high.
- Asserting reset mid-stream discards any in-flight result. Outputs hold 0 until after release.

## Configuration
- KS_INPUT_REG_EN defined:
  - A, B and Cin are captured in an input register stage before the prefix tree.
  - Latency is 2 cycles.
  - The input registers reset to 0 asynchronously with rst_n.
- KS_INPUT_REG_EN undefined:
  - Operands feed the prefix tree combinationally.
  - Latency is 1 cycle.

## Test plan
All operands at WIDTH = 16; outputs are checked after the configured latency.
- Reset: hold rst_n low while applying A=ffff, B=ffff, Cin=1 and toggling clk -> Sum=0000, Cout=0. After release, the next result follows after the configured latency.
- Zero-operand pass-through:
  - A=0000, B=1111, Cin=0 -> Sum=1111, Cout=0.
  - A=1111, B=0000, Cin=0 -> Sum=1111, Cout=0.
- Carry-in: A=0101, B=0000, Cin=1 -> Sum=0102, Cout=0.
- Full generate:
  - A=ffff, B=ffff, Cin=0 -> Sum=fffe, Cout=1.
  - A=ffff, B=ffff, Cin=1 -> Sum=ffff, Cout=1.
- Full propagate chain:
  - A=ffff, B=0000, Cin=0 -> Sum=ffff, Cout=0.
  - A=ffff, B=0000, Cin=1 -> Sum=0000, Cout=1 (carry across all 16 bits).
- Back-to-back random: new operands every cycle for ≥10,000 cycles -> each output equals the reference {Cout,Sum} = A+B+Cin from exactly latency cycles earlier. Run both with and without KS_INPUT_REG_EN.

Source files
------------

// File: rtl/ks_adder_if.sv
// Operand/result bundle for the ks_adder stage.
// master drives the operands and reads the registered result; slave is the adder.
interface ks_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  modport master (
    output A,
    output B,
    output Cin,
    input  Sum,
    input  Cout
  );

  modport slave (
    input  A,
    input  B,
    input  Cin,
    output Sum,
    output Cout
  );
endinterface

// File: rtl/ks_adder.sv
// Registered Kogge-Stone parallel-prefix adder: {Cout, Sum} = A + B + Cin.
// The carry-in is folded into bit 0 as a generate so the prefix tree yields
// every carry directly. The result is captured in an output register
// (1-cycle latency).
// Optional feature: define KS_INPUT_REG_EN to add an operand register stage
// ahead of the prefix tree (2-cycle latency).
module ks_adder #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  ks_adder_if.slave bus
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             cin_p0;
  logic [WIDTH:0]   res_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;

  // Kogge-Stone prefix tree. Returns {carry_out, sum}.
  // Bit 0 group covers position -1 (Cin), so its group-propagate is 0.
  // Cells whose span already reaches bit 0 are gray: they update G only,
  // because their P is never consumed by a later level.
  function automatic logic [WIDTH:0] ks_add(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             cin);
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] gk;
    logic [WIDTH-1:0] pk;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH:0]   c;
    pre   = a ^ b;
    gk    = a & b;
    gk[0] = gk[0] | (pre[0] & cin);
    pk    = pre;
    pk[0] = 1'b0;
    for (int k = 0; k < LEVELS; k++) begin
      gn = gk;
      pn = pk;
      for (int i = (1 << k); i < WIDTH; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i - (1 << k)]);
        if (i >= (2 << k)) begin
          pn[i] = pk[i] & pk[i - (1 << k)];
        end
      end
      gk = gn;
      pk = pn;
    end
    c = {gk, cin};
    return {c[WIDTH], pre ^ c[WIDTH-1:0]};
  endfunction

`ifdef KS_INPUT_REG_EN
  // ---- stage p0: operand register ----
  // Capture operands ahead of the prefix tree; cleared with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
    end else begin
      a_p0   <= bus.A;
      b_p0   <= bus.B;
      cin_p0 <= bus.Cin;
    end
  end
`else
  // ---- stage p0: operands feed the prefix tree directly ----
  assign a_p0   = bus.A;
  assign b_p0   = bus.B;
  assign cin_p0 = bus.Cin;
`endif

  assign res_p0 = ks_add(a_p0, b_p0, cin_p0);

  // ---- stage p1: result register ----
  // Capture sum and carry-out every cycle; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      sum_p1  <= res_p0[WIDTH-1:0];
      cout_p1 <= res_p0[WIDTH];
    end
  end

  assign bus.Sum  = sum_p1;
  assign bus.Cout = cout_p1;

endmodule

// File: tb/tb_ks_adder.sv
// Directed and back-to-back random bench for ks_adder at WIDTH = 16.
module tb_ks_adder;

`ifdef KS_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ks_adder_if #(.WIDTH(16)) bus ();

  ks_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] esum;
    logic        ecout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cout=%0b sum=%04h, expected cout=%0b sum=%04h",
               name, act[16], act[15:0], exp[16], exp[15:0]);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [16:0] expq[$];
    logic [15:0] ra, rb;
    logic        rc;
    checks = 0;
    errors = 0;

    vecs.push_back('{16'h0000, 16'h1111, 1'b0, 16'h1111, 1'b0});
    vecs.push_back('{16'h1111, 16'h0000, 1'b0, 16'h1111, 1'b0});
    vecs.push_back('{16'h0101, 16'h0000, 1'b1, 16'h0102, 1'b0});
    vecs.push_back('{16'hffff, 16'hffff, 1'b0, 16'hfffe, 1'b1});
    vecs.push_back('{16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1});
    vecs.push_back('{16'hffff, 16'h0000, 1'b0, 16'hffff, 1'b0});
    vecs.push_back('{16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'haaaa, 16'h5555, 1'b1, 16'h0000, 1'b1});
    vecs.push_back('{16'h00ff, 16'h0001, 1'b0, 16'h0100, 1'b0});
    vecs.push_back('{16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b1});

    // Reset held low while clocking with all-ones operands.
    rst_n = 1'b0;
    drive(16'hffff, 16'hffff, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {bus.Cout, bus.Sum}, 17'h0_0000);

    // Release, then the first result appears after LAT edges.
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0101, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    check("release_edge1", {bus.Cout, bus.Sum}, (LAT == 1) ? 17'h0_0102 : 17'h0_0000);
    @(posedge clk);
    #1;
    check("release_edge2", {bus.Cout, bus.Sum}, 17'h0_0102);

    // Directed table: apply each vector and check after the latency.
    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].a, vecs[n].b, vecs[n].cin);
      repeat (LAT) @(posedge clk);
      #1;
      check($sformatf("vec%0d", n), {bus.Cout, bus.Sum}, {vecs[n].ecout, vecs[n].esum});
    end

    // Back-to-back random: new operands every cycle.
    for (int n = 0; n < 10000 + LAT - 1; n++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      drive(ra, rb, rc);
      expq.push_back(17'(ra) + 17'(rb) + 17'(rc));
      @(posedge clk);
      #1;
      if (n >= LAT - 1) begin
        check("random", {bus.Cout, bus.Sum}, expq[n - LAT + 1]);
      end
    end

    // Mid-stream reset: outputs clear immediately, without a clock edge.
    @(negedge clk);
    drive(16'hffff, 16'hffff, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.Cout, bus.Sum}, 17'h0_0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_clocked", {bus.Cout, bus.Sum}, 17'h0_0000);

    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hffff, 16'h0000, 1'b1);
    repeat (LAT) @(posedge clk);
    #1;
    check("post_reset", {bus.Cout, bus.Sum}, 17'h1_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
